uart_crc_rx_ctrl: RTL and testbench

Frame controller between the UART receiver and the downstream byte consumer.
- When the receiver raises its ready flag, the controller captures the data byte and its 16-bit CRC.
- It recomputes CRC-16-CCITT over the byte, bit-serially, and compares it with the received CRC.
- Good bytes go into a small output FIFO with a valid/ready handshake; bad bytes are dropped and counted.
- It then re-arms the receiver through a clear strobe, which connects to the receiver's ready-clear input.

---
 rtl/uart_crc_rx_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_uart_crc_rx_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_crc_rx_ctrl.sv
// uart_crc_rx_ctrl: captures a UART frame (byte + CRC-16), recomputes
// CRC-16-CCITT bit-serially, pushes good bytes into a small output FIFO,
// counts bad/overflowed frames and re-arms the receiver via rx_clear.
module uart_crc_rx_ctrl #(
  parameter logic [15:0] CRC_INIT   = 16'hFFFF,
  parameter logic [15:0] CRC_POLY   = 16'h1021,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        rx_ready,
  input  logic [7:0]  rx_data,
  input  logic [15:0] rx_crc,
  output logic        rx_clear,
  output logic [7:0]  m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        frame_ok,
  output logic        frame_err,
  output logic        overflow,
  output logic [15:0] good_cnt,
  output logic [15:0] err_cnt,
  output logic [7:0]  ovf_cnt,
  output logic        busy
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, CALC, CHECK, CLEAR} state_t;

  // One MSB-first CRC-16 step with no reflection.
  function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic bit_in);
    logic fb;
    fb = crc[15] ^ bit_in;
    return {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
  endfunction

  state_t         state_r, state_nx;
  logic [7:0]     dreg_r;
  logic [15:0]    creg_r;
  logic [15:0]    crc_r;
  logic [2:0]     idx_r;
  logic [7:0]     mem_r [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr_r, rd_ptr_r;
  logic [CW-1:0]  count_r;
  logic [15:0]    good_cnt_r, err_cnt_r;
  logic [7:0]     ovf_cnt_r;
  logic           frame_ok_r, frame_err_r, overflow_r;

  logic           load_s, push_s, pop_s, can_accept_s;
  logic           ok_s, err_s, ovf_s;

  assign pop_s        = m_valid && m_ready;
  assign can_accept_s = (count_r < CW'(FIFO_DEPTH)) || pop_s;

  // Next-state and per-state control decode.
  always_comb begin
    state_nx = state_r;
    load_s   = 1'b0;
    push_s   = 1'b0;
    ok_s     = 1'b0;
    err_s    = 1'b0;
    ovf_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (rx_ready && enable) begin
          state_nx = CALC;
          load_s   = 1'b1;
        end else begin
          state_nx = IDLE;
        end
      end
      CALC: begin
        if (idx_r == 3'd0) begin
          state_nx = CHECK;
        end else begin
          state_nx = CALC;
        end
      end
      CHECK: begin
        state_nx = CLEAR;
        if (crc_r == creg_r) begin
          if (can_accept_s) begin
            push_s = 1'b1;
            ok_s   = 1'b1;
          end else begin
            ovf_s  = 1'b1;
          end
        end else begin
          err_s = 1'b1;
        end
      end
      CLEAR: begin
        if (!rx_ready) begin
          state_nx = IDLE;
        end else begin
          state_nx = CLEAR;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx;
    end
  end

  // Frame capture and bit-serial CRC recomputation.
  always_ff @(posedge clk) begin
    if (!reset) begin
      dreg_r <= 8'd0;
      creg_r <= 16'd0;
      crc_r  <= 16'd0;
      idx_r  <= 3'd0;
    end else if (load_s) begin
      dreg_r <= rx_data;
      creg_r <= rx_crc;
      crc_r  <= CRC_INIT;
      idx_r  <= 3'd7;
    end else if (state_r == CALC) begin
      crc_r  <= crc_step(crc_r, dreg_r[idx_r]);
      idx_r  <= idx_r - 3'd1;
    end
  end

  // Output FIFO storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= 8'd0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= dreg_r;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Registered one-cycle status pulses and saturating counters.
  always_ff @(posedge clk) begin
    if (!reset) begin
      frame_ok_r  <= 1'b0;
      frame_err_r <= 1'b0;
      overflow_r  <= 1'b0;
      good_cnt_r  <= 16'd0;
      err_cnt_r   <= 16'd0;
      ovf_cnt_r   <= 8'd0;
    end else begin
      frame_ok_r  <= ok_s;
      frame_err_r <= err_s;
      overflow_r  <= ovf_s;
      if (ok_s && (good_cnt_r != 16'hFFFF)) begin
        good_cnt_r <= good_cnt_r + 16'd1;
      end
      if (err_s && (err_cnt_r != 16'hFFFF)) begin
        err_cnt_r <= err_cnt_r + 16'd1;
      end
      if (ovf_s && (ovf_cnt_r != 8'hFF)) begin
        ovf_cnt_r <= ovf_cnt_r + 8'd1;
      end
    end
  end

  assign rx_clear  = (state_r == CLEAR);
  assign busy      = (state_r != IDLE);
  assign m_valid   = (count_r != '0);
  assign m_data    = mem_r[rd_ptr_r];
  assign frame_ok  = frame_ok_r;
  assign frame_err = frame_err_r;
  assign overflow  = overflow_r;
  assign good_cnt  = good_cnt_r;
  assign err_cnt   = err_cnt_r;
  assign ovf_cnt   = ovf_cnt_r;

endmodule

// File: tb/tb_uart_crc_rx_ctrl.sv
// Directed self-checking bench for uart_crc_rx_ctrl.
module tb_uart_crc_rx_ctrl;

  logic        clk = 1'b0;
  logic        reset, enable, rx_ready, m_ready;
  logic [7:0]  rx_data;
  logic [15:0] rx_crc;
  logic        rx_clear, m_valid, frame_ok, frame_err, overflow, busy;
  logic [7:0]  m_data, ovf_cnt;
  logic [15:0] good_cnt, err_cnt;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  uart_crc_rx_ctrl dut (
    .clk(clk), .reset(reset), .enable(enable), .rx_ready(rx_ready),
    .rx_data(rx_data), .rx_crc(rx_crc), .rx_clear(rx_clear),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .frame_ok(frame_ok), .frame_err(frame_err), .overflow(overflow),
    .good_cnt(good_cnt), .err_cnt(err_cnt), .ovf_cnt(ovf_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0; rx_ready = 1'b0; m_ready = 1'b0; enable = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // kind: 0 = frame_ok, 1 = frame_err, 2 = overflow
  task automatic send_frame(input logic [7:0] d, input logic [15:0] c, input int kind, input logic pop_chk);
    logic [2:0] exp_p;
    exp_p = {kind == 0, kind == 1, kind == 2};
    @(negedge clk);
    rx_ready = 1'b1; rx_data = d; rx_crc = c;
    @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_start got %b exp 1", busy); end
    repeat (8) @(posedge clk);
    @(negedge clk);
    m_ready = pop_chk;
    @(posedge clk);
    @(negedge clk);
    m_ready = 1'b0;
    checks++;
    if ({frame_ok, frame_err, overflow} !== exp_p) begin
      errors++; $display("FAIL pulses d=%h got %b exp %b", d, {frame_ok, frame_err, overflow}, exp_p);
    end
    checks++; if (rx_clear !== 1'b1) begin errors++; $display("FAIL rx_clear_high got %b exp 1", rx_clear); end
    rx_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({rx_clear, busy, frame_ok, frame_err, overflow} !== 5'b00000) begin
      errors++; $display("FAIL after_clear got %b exp 00000", {rx_clear, busy, frame_ok, frame_err, overflow});
    end
  endtask

  // Pops every byte in exp_q with m_ready held high and checks order.
  task automatic drain_expect();
    @(negedge clk);
    m_ready = 1'b1;
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (m_valid !== 1'b1 || m_data !== exp_q[i]) begin
        errors++; $display("FAIL drain[%0d] got v=%b d=%h exp v=1 d=%h", i, m_valid, m_data, exp_q[i]);
      end
      @(posedge clk);
      @(negedge clk);
    end
    m_ready = 1'b0;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got %b exp 0", m_valid); end
    exp_q.delete();
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({rx_clear, frame_ok, frame_err, overflow, m_valid, busy} !== 6'b000000) begin
      errors++; $display("FAIL reset_flags got %b exp 000000", {rx_clear, frame_ok, frame_err, overflow, m_valid, busy});
    end
    checks++; if (m_data !== 8'h00) begin errors++; $display("FAIL reset_m_data got %h exp 00", m_data); end
    checks++;
    if ({good_cnt, err_cnt, ovf_cnt} !== 40'd0) begin
      errors++; $display("FAIL reset_counters got %h %h %h exp 0", good_cnt, err_cnt, ovf_cnt);
    end
  endtask

  task automatic test_good_frame();
    apply_reset();
    send_frame(8'h41, 16'hB915, 0, 1'b0);
    checks++; if (m_valid !== 1'b1 || m_data !== 8'h41) begin
      errors++; $display("FAIL good_head got v=%b d=%h exp v=1 d=41", m_valid, m_data); end
    checks++; if (good_cnt !== 16'd1) begin errors++; $display("FAIL good_cnt got %0d exp 1", good_cnt); end
    exp_q.push_back(8'h41);
    drain_expect();
  endtask

  task automatic test_bad_frame();
    apply_reset();
    send_frame(8'h00, 16'h0000, 1, 1'b0);
    checks++; if (err_cnt !== 16'd1) begin errors++; $display("FAIL err_cnt got %0d exp 1", err_cnt); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL bad_fifo_empty got %b exp 0", m_valid); end
    checks++; if (good_cnt !== 16'd0) begin errors++; $display("FAIL bad_good_cnt got %0d exp 0", good_cnt); end
  endtask

  task automatic test_overflow();
    apply_reset();
    send_frame(8'h41, 16'hB915, 0, 1'b0);
    send_frame(8'h00, 16'hE1F0, 0, 1'b0);
    send_frame(8'h41, 16'hB915, 0, 1'b0);
    send_frame(8'h00, 16'hE1F0, 0, 1'b0);
    send_frame(8'h41, 16'hB915, 2, 1'b0);
    checks++; if (ovf_cnt !== 8'd1) begin errors++; $display("FAIL ovf_cnt got %0d exp 1", ovf_cnt); end
    checks++; if (good_cnt !== 16'd4) begin errors++; $display("FAIL ovf_good_cnt got %0d exp 4", good_cnt); end
    // Full FIFO, but the head is popped during CHECK: byte must be stored.
    send_frame(8'h41, 16'hB915, 0, 1'b1);
    checks++; if (ovf_cnt !== 8'd1) begin errors++; $display("FAIL ovf_cnt_pop got %0d exp 1", ovf_cnt); end
    checks++; if (good_cnt !== 16'd5) begin errors++; $display("FAIL good_cnt_pop got %0d exp 5", good_cnt); end
    exp_q.push_back(8'h00); exp_q.push_back(8'h41); exp_q.push_back(8'h00); exp_q.push_back(8'h41);
    drain_expect();
  endtask

  task automatic test_back_to_back();
    logic [7:0] got[$];
    int cyc;
    apply_reset();
    send_frame(8'h00, 16'hE1F0, 0, 1'b0);
    send_frame(8'h41, 16'hB915, 0, 1'b0);
    send_frame(8'h00, 16'hE1F0, 0, 1'b0);
    cyc = 0;
    while (got.size() < 3 && cyc < 200) begin
      @(negedge clk);
      m_ready = 1'($urandom_range(0, 1));
      #1;
      if (m_valid && m_ready) got.push_back(m_data);
      cyc++;
    end
    @(negedge clk);
    m_ready = 1'b0;
    checks++; if (got.size() != 3) begin errors++; $display("FAIL hs_count got %0d exp 3", got.size()); end
    else begin
      checks++; if (got[0] !== 8'h00 || got[1] !== 8'h41 || got[2] !== 8'h00) begin
        errors++; $display("FAIL hs_order got %h %h %h exp 00 41 00", got[0], got[1], got[2]); end
    end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL hs_empty got %b exp 0", m_valid); end
  endtask

  task automatic test_reset_mid_calc();
    apply_reset();
    send_frame(8'h41, 16'hB915, 0, 1'b0);  // leaves good_cnt=1 before the abort
    @(negedge clk);
    rx_ready = 1'b1; rx_data = 8'h00; rx_crc = 16'hE1F0;
    @(posedge clk);                         // edge k
    repeat (3) @(posedge clk);              // k+1..k+3
    @(negedge clk);
    reset = 1'b0; rx_ready = 1'b0;
    @(posedge clk);                         // k+4 reset edge
    @(negedge clk);
    reset = 1'b1;
    checks++; if (busy !== 1'b0 || m_valid !== 1'b0) begin
      errors++; $display("FAIL midreset_state got busy=%b v=%b exp 0 0", busy, m_valid); end
    checks++; if ({good_cnt, err_cnt, ovf_cnt} !== 40'd0) begin
      errors++; $display("FAIL midreset_cnt got %h %h %h exp 0", good_cnt, err_cnt, ovf_cnt); end
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if ({frame_ok, frame_err, overflow, rx_clear} !== 4'b0000) begin
        checks++; errors++;
        $display("FAIL midreset_pulse cyc %0d got %b exp 0000", i, {frame_ok, frame_err, overflow, rx_clear});
      end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_idle got %b exp 0", busy); end
  endtask

  task automatic test_enable();
    apply_reset();
    @(negedge clk);
    rx_ready = 1'b1; rx_data = 8'h41; rx_crc = 16'hB915;
    @(posedge clk);                         // edge k
    @(negedge clk);
    enable = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL en_busy got %b exp 1", busy); end
    repeat (9) @(posedge clk);              // k+1..k+9
    @(negedge clk);
    checks++; if (frame_ok !== 1'b1) begin errors++; $display("FAIL en_frame_ok got %b exp 1", frame_ok); end
    rx_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rx_ready = 1'b1; rx_data = 8'h00; rx_crc = 16'hE1F0;
    repeat (12) @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0 || rx_clear !== 1'b0) begin
      errors++; $display("FAIL en_blocked got busy=%b clr=%b exp 0 0", busy, rx_clear); end
    checks++; if (good_cnt !== 16'd1) begin errors++; $display("FAIL en_good_cnt got %0d exp 1", good_cnt); end
    enable = 1'b1;
    @(posedge clk);                         // new edge k
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL en_resume got %b exp 1", busy); end
    repeat (9) @(posedge clk);
    @(negedge clk);
    checks++; if (frame_ok !== 1'b1) begin errors++; $display("FAIL en_frame_ok2 got %b exp 1", frame_ok); end
    rx_ready = 1'b0;
    @(posedge clk);
    exp_q.push_back(8'h41); exp_q.push_back(8'h00);
    drain_expect();
  endtask

  task automatic test_saturation();
    apply_reset();
    @(negedge clk);
    force dut.err_cnt_r = 16'hFFFF;
    #1;
    release dut.err_cnt_r;
    checks++; if (err_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_preload got %h exp FFFF", err_cnt); end
    send_frame(8'h00, 16'h0000, 1, 1'b0);
    checks++; if (err_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_hold got %h exp FFFF", err_cnt); end
  endtask

  initial begin
    reset = 1'b0; enable = 1'b1; rx_ready = 1'b0; m_ready = 1'b0;
    rx_data = 8'h00; rx_crc = 16'h0000;
    test_reset();
    test_good_frame();
    test_bad_frame();
    test_overflow();
    test_back_to_back();
    test_reset_mid_calc();
    test_enable();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
